// File: rtl/lfsr_pkg.sv
// Shared types and constants for the 7-bit LFSR tap-finder and its encrypt-side peer.
// Holds the tap table, the tap-index/state typedefs, the finder FSM encoding and a
// bounds-safe tap lookup helper.
package lfsr_pkg;

    localparam int unsigned NUM_TAP_ENTRIES = 9;

    typedef logic [3:0] tap_idx_t;
    typedef logic [6:0] lfsr_t;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StSearch,
        StDone
    } finder_state_e;

    localparam tap_idx_t TAP_NONE = 4'hF;

    localparam lfsr_t TAP_TABLE [NUM_TAP_ENTRIES] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // Indices past the table yield an all-zero tap rather than an X.
    function automatic lfsr_t tap_lookup(tap_idx_t idx);
        if (idx < 4'(NUM_TAP_ENTRIES)) begin
            return TAP_TABLE[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/lfsr_tap_finder_step.sv
// One step of the 7-bit Fibonacci LFSR: shift left, feed back the parity of the tapped bits.
// Ports:
//   state_i  current LFSR state
//   tap_i    tap pattern (1 = bit participates in feedback)
//   next_o   state after one step
module lfsr7_step
    import lfsr_pkg::*;
(
    input  logic [6:0] state_i,
    input  logic [6:0] tap_i,
    output logic [6:0] next_o
);

    lfsr_t masked;

    assign masked = state_i & tap_i;
    assign next_o = {state_i[5:0], ^masked};

endmodule

// File: rtl/lfsr_tap_finder.sv
// Recovers the tap index and seed of a 7-bit LFSR cipher from a known-plaintext preamble.
// Fetches PRE_LEN ciphertext bytes, strips KNOWN_CHAR, then walks the tap table with
// early exit on the first mismatch; the lowest matching tap index wins.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   start_i      request pulse, honoured only when idle
//   base_addr_i  address of ciphertext byte 0, sampled with start_i
//   mem_addr_o   data-memory read address
//   mem_data_i   read data, one cycle after mem_addr_o; bit 7 ignored
//   busy_o       search in progress
//   done_o       one-cycle end-of-search pulse
//   found_o      a matching tap was found
//   tap_index_o  winning tap index, TAP_NONE if none
//   seed_o       recovered seed, 0 if none
module lfsr_tap_finder
    import lfsr_pkg::*;
#(
    parameter int unsigned PRE_LEN    = 6,
    parameter int unsigned NUM_TAPS   = 9,
    parameter logic [6:0]  KNOWN_CHAR = 7'h20
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] base_addr_i,
    output logic [7:0] mem_addr_o,
    input  logic [7:0] mem_data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       found_o,
    output logic [3:0] tap_index_o,
    output logic [6:0] seed_o
);

    localparam logic [4:0] KLast = 5'(PRE_LEN);
    localparam logic [3:0] JLast = 4'(PRE_LEN - 1);
    localparam tap_idx_t   TLast = 4'(NUM_TAPS - 1);

    finder_state_e state_q, state_d;
    logic [7:0]    base_q, base_d;
    logic [4:0]    k_q, k_d;
    lfsr_t         pre_q [PRE_LEN];
    lfsr_t         pre_d [PRE_LEN];
    tap_idx_t      t_q, t_d;
    logic [3:0]    j_q, j_d;
    lfsr_t         s_q, s_d;
    logic          found_q, found_d;
    tap_idx_t      tap_q, tap_d;
    lfsr_t         seed_q, seed_d;

    lfsr_t step_next;
    logic  unused_mem_msb;

    assign unused_mem_msb = mem_data_i[7];

    lfsr7_step u_step (
        .state_i (s_q),
        .tap_i   (tap_lookup(t_q)),
        .next_o  (step_next)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            base_q  <= '0;
            k_q     <= '0;
            pre_q   <= '{default: '0};
            t_q     <= '0;
            j_q     <= '0;
            s_q     <= '0;
            found_q <= 1'b0;
            tap_q   <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            k_q     <= k_d;
            pre_q   <= pre_d;
            t_q     <= t_d;
            j_q     <= j_d;
            s_q     <= s_d;
            found_q <= found_d;
            tap_q   <= tap_d;
            seed_q  <= seed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        k_d     = k_q;
        pre_d   = pre_q;
        t_d     = t_q;
        j_d     = j_q;
        s_d     = s_q;
        found_d = found_q;
        tap_d   = tap_q;
        seed_d  = seed_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    base_d  = base_addr_i;
                    k_d     = '0;
                    found_d = 1'b0;
                    tap_d   = '0;
                    seed_d  = '0;
                end
            end
            StFetch: begin
                // Data for the address driven in cycle k-1 arrives in cycle k.
                if (k_q != '0) begin
                    pre_d[k_q - 5'd1] = mem_data_i[6:0] ^ KNOWN_CHAR;
                end
                if (k_q == KLast) begin
                    state_d = StSearch;
                    t_d     = '0;
                    j_d     = 4'd1;
                    s_d     = pre_q[0];
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            StSearch: begin
                if (step_next == pre_q[j_q]) begin
                    if (j_q == JLast) begin
                        state_d = StDone;
                        found_d = 1'b1;
                        tap_d   = t_q;
                        seed_d  = pre_q[0];
                    end else begin
                        s_d = step_next;
                        j_d = j_q + 4'd1;
                    end
                end else if (t_q != TLast) begin
                    t_d = t_q + 4'd1;
                    j_d = 4'd1;
                    s_d = pre_q[0];
                end else begin
                    state_d = StDone;
                    found_d = 1'b0;
                    tap_d   = TAP_NONE;
                    seed_d  = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_addr_o  = base_q + {3'b000, k_q};
    assign busy_o      = (state_q == StFetch) || (state_q == StSearch);
    assign done_o      = (state_q == StDone);
    assign found_o     = found_q;
    assign tap_index_o = tap_q;
    assign seed_o      = seed_q;

endmodule

// File: doc/lfsr_tap_finder.md
Name: lfsr_tap_finder

Overview:
- Decryption-side counterpart of the processor's 7-bit LFSR tap table: the table maps a tap index to a tap pattern; this block recovers the tap index and seed from an encrypted message.
- Fetches the first PRE_LEN ciphertext bytes from data memory. Every byte is known to encrypt KNOWN_CHAR.
- Steps all NUM_TAPS candidate LFSRs and reports the first tap index, and the seed, that reproduce the preamble.
- Sits beside data memory as a hardware assist for the decrypt program.

Parameters:
- PRE_LEN, 6, number of preamble bytes fetched and checked (range 2..16)
- NUM_TAPS, 9, number of candidate tap patterns (indices 0..NUM_TAPS-1)
- KNOWN_CHAR, 7'h20, plaintext value of every preamble byte

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-low reset
- Start  in  1  one-cycle request pulse; sampled only in IDLE
- BaseAddr  in  8  address of ciphertext byte 0; sampled with Start
- MemAddr  out  8  data-memory read address
- MemData  in  8  read data; valid one cycle after MemAddr; bit 7 ignored
- Busy  out  1  high from the cycle after Start is accepted until Done
- Done  out  1  one-cycle pulse when the search ends
- Found  out  1  1 = a matching tap was found
- TapIndex  out  4  winning tap index; 4'hF when not found
- Seed  out  7  recovered LFSR seed; 0 when not found

Behaviour:
- Reset (Reset==0 at an edge): state=IDLE. Busy=0, Done=0, Found=0, TapIndex=0, Seed=0, MemAddr=0. Preamble buffer, counters and LFSR state cleared. Reset mid-search aborts with no Done pulse.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- Tap table, indices 0..8: 7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B.
- Plain byte k: p[k] = MemData[6:0] ^ KNOWN_CHAR.
- FSM states: IDLE, FETCH, SEARCH, DONE.
- IDLE:
  - Start=1 latches BaseAddr, sets k=0, goes to FETCH, Busy=1.
  - Start while not in IDLE is ignored.
- FETCH:
  - Drives MemAddr = BaseAddr + k (mod 256, wraps 8'hFF -> 8'h00) for k = 0..PRE_LEN-1, one per cycle.
  - Captures p[k] one cycle after each address is driven.
  - After the last capture (PRE_LEN+1 cycles in FETCH) goes to SEARCH with t=0, j=1, s=p[0].
- SEARCH: one comparison per cycle.
  - Compute n = step(s, tap[t]).
  - If n==p[j] and j==PRE_LEN-1: Found=1, TapIndex=t, Seed=p[0]; go to DONE.
  - Else if n==p[j]: s<=n, j<=j+1.
  - Else, with t<NUM_TAPS-1: t<=t+1, j<=1, s<=p[0] (early exit on first mismatch).
  - Else, with t==NUM_TAPS-1: Found=0, TapIndex=4'hF, Seed=0; go to DONE.
- Tie-break: lowest matching index wins. A zero seed (s=0) matches tap 0 whenever all p[k]==0.
- DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Outputs hold: Found, TapIndex and Seed hold until the next accepted Start, which clears them to 0 in the acceptance cycle.
- Latency: Done rises PRE_LEN + 1 + S + 1 cycles after the Start edge, where S = number of SEARCH cycles.
- Search bound: S is at most NUM_TAPS*(PRE_LEN-1), i.e. 45 for the defaults.

Decomposition:
- Package lfsr_pkg holds:
  - TAP_TABLE constant array (9 x 7 bits)
  - tap_idx_t (4-bit) and lfsr_t (7-bit) typedefs
  - finder state enum
  - TAP_NONE = 4'hF
- One sub-module: lfsr7_step. Combinational, inputs state and tap, output next state. It is reused by the encrypt path and the testbench model.

Test Plan:
- Zero preamble: memory[0x10..0x15] = 0x20 x6, BaseAddr=0x10 -> Found=1, TapIndex=0, Seed=0x00. Done 7+5+1=13 cycles after Start.
- Tap 0, seed 0x01: bytes 0x21,0x22,0x24,0x28,0x30,0x00 -> Found=1, TapIndex=0, Seed=0x01. Busy high 12 cycles, Done pulse width 1.
- Later tap (e.g. index 3, 7'h72, seed 0x55) generated by the lfsr7_step model -> Found=1, TapIndex = lowest matching index per the model (3 unless a lower tap aliases), Seed=0x55. MemData bit 7 randomized with no effect.
- No match: bytes 0x20,0x7F,0x20,0x20,0x20,0x20 -> Found=0, TapIndex=4'hF, Seed=0. S=9, Done 17 cycles after Start.
- Address wrap: BaseAddr=0xFD -> MemAddr sequence 0xFD,0xFE,0xFF,0x00,0x01,0x02.
- Control corners:
  - Start asserted during Busy is ignored.
  - Reset low mid-SEARCH: outputs zero next cycle, no Done pulse.
  - New Start after Done clears the previous results.
